// File: rtl/enc_track_pkg.sv
// Shared types and helpers for the hash-encoding request tracker.
// The popcount helper counts up to PC_MAX bits, so callers zero-extend narrower vectors.
package enc_track_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    OPEN   = 2'd1,
    SEALED = 2'd2,
    DONE   = 2'd3
  } row_state_e;

  localparam int NUM_ROW_DEF = 32;
  localparam int NUM_COL_DEF = 128;
  localparam int PC_MAX      = 256;
  localparam int PC_W        = $clog2(PC_MAX + 1);

  function automatic logic [PC_W-1:0] popcount(input logic [PC_MAX-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < PC_MAX; i++) begin
      c = c + PC_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/enc_track_row.sv
// One tracked row: lifecycle state, dispatched-column mask, expected and returned counts.
// Errors are judged on the start-of-cycle state; a free on a live row overrides everything else.
module enc_track_row
  import enc_track_pkg::*;
#(
  parameter int NUM_COL   = NUM_COL_DEF,
  parameter int CNT_W     = $clog2(NUM_COL_DEF + 1),
  parameter int SUM_W     = CNT_W + 2,
  parameter int AUTO_FREE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alloc_i,
  input  logic               sent_i,
  input  logic [NUM_COL-1:0] sent_mask_i,
  input  logic               seal_i,
  input  logic               ret_hit_i,
  input  logic [SUM_W-1:0]   ret_sum_i,
  input  logic               free_i,
  input  logic               ack_i,
  output logic               is_free_o,
  output logic               is_done_o,
  output logic               free_nxt_o,
  output logic               err_o
);

  row_state_e         state_q, state_d;
  logic [NUM_COL-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]   exp_q, exp_d;
  logic [CNT_W-1:0]   ret_q, ret_d;
  logic               acked_q, acked_d;
  logic [SUM_W-1:0]   ret_new;
  logic               free_win;

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    exp_d    = exp_q;
    ret_d    = ret_q;
    acked_d  = acked_q;
    err_o    = 1'b0;
    ret_new  = '0;
    free_win = free_i && (state_q != FREE);
    if (!free_win) begin
      if (sent_i) begin
        if (state_q == OPEN) begin
          exp_d  = exp_q + CNT_W'(popcount(PC_MAX'(sent_mask_i & ~mask_q)));
          mask_d = mask_q | sent_mask_i;
        end else begin
          err_o = 1'b1;
        end
      end
      if (seal_i && (state_q != OPEN)) err_o = 1'b1;
      if (ret_hit_i) begin
        if ((state_q == OPEN) || (state_q == SEALED)) begin
          // An over-return is rejected whole so the row can still complete correctly.
          ret_new = SUM_W'(ret_q) + ret_sum_i;
          if (ret_new > SUM_W'(exp_d)) err_o = 1'b1;
          else ret_d = CNT_W'(ret_new);
        end else begin
          err_o = 1'b1;
        end
      end
      case (state_q)
        FREE:    if (alloc_i) state_d = OPEN;
        OPEN:    if (seal_i) state_d = SEALED;
        SEALED:  if (ret_d == exp_d) state_d = DONE;
        DONE: begin
          if (ack_i) begin
            acked_d = 1'b1;
            if (AUTO_FREE != 0) state_d = FREE;
          end
        end
        default: state_d = FREE;
      endcase
    end else begin
      state_d = FREE;
    end
    if (state_d == FREE) begin
      mask_d  = '0;
      exp_d   = '0;
      ret_d   = '0;
      acked_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FREE;
      mask_q  <= '0;
      exp_q   <= '0;
      ret_q   <= '0;
      acked_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      exp_q   <= exp_d;
      ret_q   <= ret_d;
      acked_q <= acked_d;
    end
  end

  assign is_free_o  = (state_q == FREE);
  assign is_done_o  = (state_q == DONE) && !acked_q;
  assign free_nxt_o = (state_d == FREE);

endmodule

// File: rtl/enc_track_table.sv
// Row allocator and completion tracker for in-flight hash-encoding batches.
// Done queue: done_row is held while done_valid && !done_ready; the event completes on done_valid && done_ready.
module enc_track_table
  import enc_track_pkg::*;
#(
  parameter int NUM_ROW    = NUM_ROW_DEF,
  parameter int NUM_COL    = NUM_COL_DEF,
  parameter int NUM_RET_CH = 2,
  parameter int AUTO_FREE  = 1,
  localparam int ROW_W     = $clog2(NUM_ROW),
  localparam int CNT_W     = $clog2(NUM_COL + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alloc_req,
  output logic                        alloc_gnt,
  output logic [ROW_W-1:0]            alloc_row,
  input  logic                        sent_en,
  input  logic [ROW_W-1:0]            sent_row,
  input  logic [NUM_COL-1:0]          sent_mask,
  input  logic                        seal_en,
  input  logic [ROW_W-1:0]            seal_row,
  input  logic [NUM_RET_CH-1:0]       ret_en,
  input  logic [NUM_RET_CH*ROW_W-1:0] ret_row,
  input  logic [NUM_RET_CH*CNT_W-1:0] ret_num,
  input  logic                        free_en,
  input  logic [ROW_W-1:0]            free_row,
  output logic                        done_valid,
  output logic [ROW_W-1:0]            done_row,
  input  logic                        done_ready,
  output logic                        full,
  output logic [ROW_W:0]              free_cnt,
  output logic                        err
);

  localparam int SUM_W = CNT_W + $clog2(NUM_RET_CH) + 1;

  logic [NUM_ROW-1:0] free_vec, done_vec, free_nxt_vec, row_err, free_hit, done_cand;
  logic               ret_hit [NUM_ROW];
  logic [SUM_W-1:0]   ret_sum [NUM_ROW];
  logic               alloc_fire, done_ack;
  logic [ROW_W-1:0]   alloc_idx;

  logic               alloc_gnt_q, alloc_gnt_d;
  logic [ROW_W-1:0]   alloc_row_q, alloc_row_d;
  logic               done_valid_q, done_valid_d;
  logic [ROW_W-1:0]   done_row_q, done_row_d;
  logic               full_q, full_d;
  logic [ROW_W:0]     free_cnt_q, free_cnt_d;
  logic               err_q, err_d;

  function automatic logic [ROW_W-1:0] lowest(input logic [NUM_ROW-1:0] v);
    logic [ROW_W-1:0] idx;
    idx = '0;
    for (int i = NUM_ROW - 1; i >= 0; i--) begin
      if (v[i]) idx = ROW_W'(i);
    end
    return idx;
  endfunction

  // Return crossbar: every channel aimed at a row adds into that row's sum.
  always_comb begin
    for (int r = 0; r < NUM_ROW; r++) begin
      ret_hit[r] = 1'b0;
      ret_sum[r] = '0;
      for (int c = 0; c < NUM_RET_CH; c++) begin
        if (ret_en[c] && (ret_row[c*ROW_W +: ROW_W] == ROW_W'(r))) begin
          ret_hit[r] = 1'b1;
          ret_sum[r] = ret_sum[r] + SUM_W'(ret_num[c*CNT_W +: CNT_W]);
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_ROW; g++) begin : g_row
    assign free_hit[g] = free_en && (free_row == ROW_W'(g));
    enc_track_row #(
      .NUM_COL  (NUM_COL),
      .CNT_W    (CNT_W),
      .SUM_W    (SUM_W),
      .AUTO_FREE(AUTO_FREE)
    ) u_row (
      .clk        (clk),
      .rst        (rst),
      .alloc_i    (alloc_fire && (alloc_idx == ROW_W'(g))),
      .sent_i     (sent_en && (sent_row == ROW_W'(g))),
      .sent_mask_i(sent_mask),
      .seal_i     (seal_en && (seal_row == ROW_W'(g))),
      .ret_hit_i  (ret_hit[g]),
      .ret_sum_i  (ret_sum[g]),
      .free_i     (free_hit[g]),
      .ack_i      (done_ack && (done_row_q == ROW_W'(g))),
      .is_free_o  (free_vec[g]),
      .is_done_o  (done_vec[g]),
      .free_nxt_o (free_nxt_vec[g]),
      .err_o      (row_err[g])
    );
  end

  assign alloc_fire = alloc_req && (|free_vec);
  assign alloc_idx  = lowest(free_vec);
  // A row being freed this cycle must not be presented as done.
  assign done_cand  = done_vec & ~free_hit;

  always_comb begin
    alloc_gnt_d  = alloc_fire;
    alloc_row_d  = alloc_fire ? alloc_idx : alloc_row_q;
    done_valid_d = done_valid_q;
    done_row_d   = done_row_q;
    done_ack     = 1'b0;
    if (done_valid_q) begin
      if (done_ready) begin
        done_valid_d = 1'b0;
        done_ack     = 1'b1;
      end else if (free_en && (free_row == done_row_q)) begin
        done_valid_d = 1'b0;
      end
    end else if (|done_cand) begin
      done_valid_d = 1'b1;
      done_row_d   = lowest(done_cand);
    end
    // Counted from next-state so the count moves in the same cycle as alloc_gnt.
    free_cnt_d = (ROW_W+1)'(popcount(PC_MAX'(free_nxt_vec)));
    full_d     = ~(|free_nxt_vec);
    err_d      = err_q | (|row_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alloc_gnt_q  <= 1'b0;
      alloc_row_q  <= '0;
      done_valid_q <= 1'b0;
      done_row_q   <= '0;
      full_q       <= 1'b0;
      free_cnt_q   <= (ROW_W+1)'(NUM_ROW);
      err_q        <= 1'b0;
    end else begin
      alloc_gnt_q  <= alloc_gnt_d;
      alloc_row_q  <= alloc_row_d;
      done_valid_q <= done_valid_d;
      done_row_q   <= done_row_d;
      full_q       <= full_d;
      free_cnt_q   <= free_cnt_d;
      err_q        <= err_d;
    end
  end

  assign alloc_gnt  = alloc_gnt_q;
  assign alloc_row  = alloc_row_q;
  assign done_valid = done_valid_q;
  assign done_row   = done_row_q;
  assign full       = full_q;
  assign free_cnt   = free_cnt_q;
  assign err        = err_q;

endmodule
